// File: rtl/csa_bist_ctrl_if.sv
// Add interface between the BIST engine (master: drives operands) and the adder under test (slave).
interface csa_add_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] dut_a;
  logic [WIDTH-1:0] dut_b;
  logic             dut_cin;
  logic [WIDTH-1:0] dut_s;
  logic             dut_cout;

  modport master (
    output dut_a, dut_b, dut_cin,
    input  dut_s, dut_cout
  );

  modport slave (
    input  dut_a, dut_b, dut_cin,
    output dut_s, dut_cout
  );
endinterface

// File: rtl/csa_bist_ctrl.sv
// Self-test stimulus/response engine for the carry-skip adder: LFSR vectors in, golden a+b+cin compare.
// Optional first-failure capture ports are built when CSA_BIST_FIRST_FAIL_EN is defined.
//
// state    | meaning
// S_IDLE   | waiting for start after reset
// S_DRIVE  | register next LFSR vector onto the adder operands
// S_SETTLE | hold operands SETTLE_CYCLES cycles
// S_CHECK  | compare adder result, update counts, advance LFSR
// S_DONE   | run finished, results held until next start
module csa_bist_ctrl #(
  parameter int          WIDTH         = 4,
  parameter int          NUM_VECTORS   = 20,
  parameter int          SETTLE_CYCLES = 1,
  parameter logic [31:0] SEED          = 32'h1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  csa_add_if.master   add,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [15:0] vec_count
`ifdef CSA_BIST_FIRST_FAIL_EN
  ,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic             fail_cin,
  output logic             fail_valid
`endif
);

  localparam logic [31:0] POLY    = 32'h8020_0003;
  localparam int          CW      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [15:0] NUM_VEC = 16'(NUM_VECTORS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t        state;
  logic [31:0]   lfsr;
  logic [CW-1:0] settle_cnt;

  logic [WIDTH:0] sum_exp;
  logic           mismatch;
  logic [15:0]    err_next;
  logic [15:0]    vec_next;
  logic [31:0]    lfsr_next;

  always_comb begin
    sum_exp   = {1'b0, add.dut_a} + {1'b0, add.dut_b} + {{WIDTH{1'b0}}, add.dut_cin};
    mismatch  = ({add.dut_cout, add.dut_s} != sum_exp);
    err_next  = (mismatch && (err_count != 16'hFFFF)) ? err_count + 16'd1 : err_count;
    vec_next  = vec_count + 16'd1;
    lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? POLY : 32'h0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      lfsr        <= SEED;
      settle_cnt  <= '0;
      add.dut_a   <= '0;
      add.dut_b   <= '0;
      add.dut_cin <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_count   <= '0;
      vec_count   <= '0;
`ifdef CSA_BIST_FIRST_FAIL_EN
      fail_a      <= '0;
      fail_b      <= '0;
      fail_cin    <= 1'b0;
      fail_valid  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_DRIVE;
            lfsr      <= SEED;
            err_count <= '0;
            vec_count <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
`ifdef CSA_BIST_FIRST_FAIL_EN
            fail_a     <= '0;
            fail_b     <= '0;
            fail_cin   <= 1'b0;
            fail_valid <= 1'b0;
`endif
          end
        end
        S_DRIVE: begin
          // a in the MSBs of the vector, cin in bit 0
          add.dut_a   <= lfsr[2*WIDTH:WIDTH+1];
          add.dut_b   <= lfsr[WIDTH:1];
          add.dut_cin <= lfsr[0];
          settle_cnt  <= SETTLE_LOAD;
          state       <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_cnt == '0) state <= S_CHECK;
          else                  settle_cnt <= settle_cnt - 1'b1;
        end
        S_CHECK: begin
          err_count <= err_next;
          vec_count <= vec_next;
          lfsr      <= lfsr_next;
`ifdef CSA_BIST_FIRST_FAIL_EN
          if (mismatch && !fail_valid) begin
            fail_a     <= add.dut_a;
            fail_b     <= add.dut_b;
            fail_cin   <= add.dut_cin;
            fail_valid <= 1'b1;
          end
`endif
          if (vec_next == NUM_VEC) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == 16'd0);
          end else begin
            state <= S_DRIVE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
